alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares the single 3-bit ALU (select S[1:0], operands A[2:0]/B[2:0], result ans[4:0]) among NUM_REQ requesters.
- Accepts one operation at a time, drives the ALU inputs and waits ALU_LAT cycles. It then captures ans and returns it to the owning requester with a one-cycle done pulse.
- Sits between requester logic and the ALU instance; the ALU itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- ALU_LAT, 1, cycles from operands driven to ans sampled (1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  per-requester request, level.
- op_flat  input  2*NUM_REQ  per-requester ALU select; requester k uses bits [2k+1:2k].
- a_flat  input  3*NUM_REQ  per-requester operand A; requester k uses bits [3k+2:3k].
- b_flat  input  3*NUM_REQ  per-requester operand B; same packing as a_flat.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: operands of that requester accepted.
- done  output  NUM_REQ  one-hot, one-cycle pulse: result valid for that requester.
- result  output  5  captured ALU result, holds until next capture.
- busy  output  1  high while an operation is in flight (EXEC).
- alu_s  output  2  to ALU S.
- alu_a  output  3  to ALU A.
- alu_b  output  3  to ALU B.
- alu_ans  input  5  from ALU ans.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, gnt=0, done=0, result=0, busy=0, alu_s/a/b=0, rr pointer ptr=0, latency counter=0, owner=0. Reset overrides everything, including a mid-operation transaction: that operation is discarded and no done is issued.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick a winner w as the first set req bit searching from ptr upward, wrapping modulo NUM_REQ.
  - On the edge: latch op/a/b of w into alu_s/alu_a/alu_b, set owner=w, gnt[w]=1 for one cycle, busy=1, cnt=0, ptr=(w+1) mod NUM_REQ, state=EXEC.
- EXEC:
  - alu_s/a/b held stable; cnt increments each cycle.
  - On the edge ending the ALU_LAT-th EXEC cycle: result<=alu_ans, done[owner]=1 for one cycle, busy=0, state=IDLE.
- Timing at ALU_LAT=1: req seen in cycle t; gnt in t+1; done and result in t+2. The IDLE cycle carrying done also arbitrates, so back-to-back period is ALU_LAT+1 cycles.
- Handshake:
  - A requester holds req and its operands stable until it sees gnt.
  - It must drop req in the cycle after gnt unless it issues a new request.
  - Operands are sampled only at the grant edge; later changes have no effect on the operation in flight.
- req changes during EXEC are ignored until IDLE.
- Requests from deasserted requesters are never granted, and a request dropped before grant is lost silently.
- alu_s/a/b keep the last operation's operands while IDLE; they are not zeroed.
- result holds its value; only done marks it fresh.
- gnt and done are never asserted for more than one requester at a time; both are registered outputs.
- Width rules:
  - result is alu_ans unmodified (5 bits); the arbiter performs no arithmetic on data.
  - cnt is 2 bits, compared against ALU_LAT-1.
  - ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds output op_count[15:0]. It increments on every done pulse, saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench ALU model: S=0 -> A+B, S=1 -> A-B mod 32, S=2 -> A&B, S=3 -> A|B, zero-extended to 5 bits.
- Reset: rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, done=0, result=0, busy=0, alu_s/a/b=0 throughout.
- Single op: req[0]=1 with S=0, A=3, B=5, dropped after gnt -> gnt=4'b0001 at t+1, done=4'b0001 and result=8 at t+2, busy high only in t+1.
- Simultaneous: req=4'b1111 held, each requester drops after its gnt; ops {S=0,7,7}, {S=1,2,5}, {S=2,6,3}, {S=3,4,1} -> grant order 0,1,2,3 every 2 cycles. Results 14, 29, 2, 5 with done on matching bits.
- Fairness: req[1] and req[3] held continuously, ptr starting at 0 -> grant order 1,3,1,3,1,3, never the same requester twice in a row. Repeat with ALU_LAT=3: period 4 cycles, done 3 cycles after gnt.
- Reset mid-op: rst_n=0 in the EXEC cycle after gnt[2] -> no done pulse ever appears for requester 2. busy=0 and ptr=0 after reset; the next request from requester 0 is granted first.
- Stats (macro defined): 10 completed ops -> op_count=10; after a reset -> 0. With the macro undefined, the build has no op_count port.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Requester/ALU bundle for alu_share_arb: the arbiter uses the slave modport and the
// requester/ALU side uses the master modport.
interface alu_share_arb_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] op_flat;
  logic [3*NUM_REQ-1:0] a_flat;
  logic [3*NUM_REQ-1:0] b_flat;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [4:0]           result;
  logic                 busy;
  logic [1:0]           alu_s;
  logic [2:0]           alu_a;
  logic [2:0]           alu_b;
  logic [4:0]           alu_ans;

  modport slave (
    input  req, op_flat, a_flat, b_flat, alu_ans,
    output gnt, done, result, busy, alu_s, alu_a, alu_b
  );

  modport master (
    output req, op_flat, a_flat, b_flat, alu_ans,
    input  gnt, done, result, busy, alu_s, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one 3-bit ALU among NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add the saturating op_count output.
module alu_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_share_arb_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]   op_count
`endif
);

  localparam int unsigned PtrW    = $clog2(NUM_REQ);
  localparam logic [1:0]  CntLast = 2'(ALU_LAT - 1);

  typedef enum logic {StIdle, StExec} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d, owner_q, owner_d, win;
  logic                win_valid;
  logic [1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [4:0]          result_q, result_d;
  logic                busy_q, busy_d;
  logic [1:0]          alu_s_q, alu_s_d, win_s;
  logic [2:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d, win_a, win_b;

  // First requesting index at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PtrW:0] idx;
    idx       = '0;
    win       = '0;
    win_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (PtrW + 1)'(i);
      if (idx >= (PtrW + 1)'(NUM_REQ)) idx = idx - (PtrW + 1)'(NUM_REQ);
      if (!win_valid && bus.req[idx[PtrW-1:0]]) begin
        win_valid = 1'b1;
        win       = idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    win_s = '0;
    win_a = '0;
    win_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win == PtrW'(k)) begin
        win_s = bus.op_flat[2*k +: 2];
        win_a = bus.a_flat[3*k +: 3];
        win_b = bus.b_flat[3*k +: 3];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result_q;
    busy_d   = busy_q;
    alu_s_d  = alu_s_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          alu_s_d    = win_s;
          alu_a_d    = win_a;
          alu_b_d    = win_b;
          owner_d    = win;
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          ptr_d      = (win == PtrW'(NUM_REQ - 1)) ? '0 : win + PtrW'(1);
          state_d    = StExec;
        end
      end
      StExec: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CntLast) begin
          result_d        = bus.alu_ans;
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      alu_s_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      alu_s_q  <= alu_s_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.alu_s  = alu_s_q;
  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (|done_d && op_count_q != 16'hFFFF) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: hand sequences, a vector table and a randomized run
// against a transaction-level model; ALU_LAT=1 and ALU_LAT=3 instances.
module tb_alu_share_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_share_arb_if #(.NUM_REQ(4)) bus1 ();
  alu_share_arb_if #(.NUM_REQ(4)) bus3 ();

  function automatic logic [4:0] alu_f(input logic [1:0] s, input logic [2:0] a,
                                       input logic [2:0] b);
    int r;
    case (s)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = (int'(a) - int'(b) + 32) % 32;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 5'(r);
  endfunction

  assign bus1.alu_ans = alu_f(bus1.alu_s, bus1.alu_a, bus1.alu_b);
  assign bus3.alu_ans = alu_f(bus3.alu_s, bus3.alu_a, bus3.alu_b);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_count1, op_count3;
`endif

  alu_share_arb #(.NUM_REQ(4), .ALU_LAT(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus1)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_count (op_count1)
`endif
  );

  alu_share_arb #(.NUM_REQ(4), .ALU_LAT(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus3)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_count (op_count3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_op1(input int k, input logic [1:0] s, input logic [2:0] a,
                         input logic [2:0] b);
    bus1.op_flat[2*k +: 2] = s;
    bus1.a_flat[3*k +: 3]  = a;
    bus1.b_flat[3*k +: 3]  = b;
  endtask

  // Fairness reference for req=4'b1010 held from a fresh reset: grants alternate 1,3,...
  function automatic void fair_exp(input int s, input int lat, output logic [3:0] g,
                                   output logic [3:0] d, output logic [4:0] r, output logic b);
    int ph, n, who;
    ph  = (s - 1) % (lat + 1);
    n   = (s - 1) / (lat + 1);
    who = (n % 2 == 0) ? 1 : 3;
    g   = (ph == 0) ? 4'(1 << who) : 4'd0;
    d   = (ph == lat) ? 4'(1 << who) : 4'd0;
    r   = (who == 1) ? 5'd3 : 5'd7;
    b   = (ph < lat);
  endfunction

  typedef struct {
    int         k;
    logic [1:0] s;
    logic [2:0] a;
    logic [2:0] b;
    logic [4:0] exp;
  } vec_t;

  // Transaction-level model: one op in flight, done LAT edges after grant, next grant after.
  bit         m_busy;
  int         m_done_at, m_owner, m_ptr, m_edge;
  logic [1:0] m_s;
  logic [2:0] m_a, m_b;
  logic [4:0] m_res;
  logic [3:0] e_gnt, e_done;

  task automatic model_edge(input int lat);
    e_gnt  = '0;
    e_done = '0;
    if (m_busy) begin
      if (m_edge == m_done_at) begin
        e_done[m_owner] = 1'b1;
        m_res  = alu_f(m_s, m_a, m_b);
        m_busy = 1'b0;
      end
    end else if (bus1.req != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        int w;
        w = (m_ptr + i) % 4;
        if (!m_busy && bus1.req[w]) begin
          e_gnt[w]  = 1'b1;
          m_s       = bus1.op_flat[2*w +: 2];
          m_a       = bus1.a_flat[3*w +: 3];
          m_b       = bus1.b_flat[3*w +: 3];
          m_owner   = w;
          m_busy    = 1'b1;
          m_done_at = m_edge + lat;
          m_ptr     = (w + 1) % 4;
        end
      end
    end
    m_edge++;
  endtask

  vec_t vecs[8];
  logic [1:0] sim_s[4];
  logic [2:0] sim_a[4], sim_b[4];
  logic [4:0] sim_r[4];

  initial begin
    logic [3:0] g, d;
    logic [4:0] r;
    logic       b;

    vecs[0] = '{0, 2'd0, 3'd3, 3'd5, 5'd8};
    vecs[1] = '{1, 2'd0, 3'd7, 3'd7, 5'd14};
    vecs[2] = '{2, 2'd1, 3'd0, 3'd1, 5'd31};
    vecs[3] = '{3, 2'd1, 3'd5, 3'd5, 5'd0};
    vecs[4] = '{0, 2'd2, 3'd5, 3'd3, 5'd1};
    vecs[5] = '{1, 2'd3, 3'd4, 3'd2, 5'd6};
    vecs[6] = '{2, 2'd3, 3'd7, 3'd0, 5'd7};
    vecs[7] = '{3, 2'd2, 3'd7, 3'd7, 5'd7};
    sim_s = '{2'd0, 2'd1, 2'd2, 2'd3};
    sim_a = '{3'd7, 3'd2, 3'd6, 3'd4};
    sim_b = '{3'd7, 3'd5, 3'd3, 3'd1};
    sim_r = '{5'd14, 5'd29, 5'd2, 5'd5};

    bus1.op_flat = '0; bus1.a_flat = '0; bus1.b_flat = '0;
    bus3.op_flat = '0; bus3.a_flat = '0; bus3.b_flat = '0;

    // Reset with every request asserted
    rst_n    = 1'b0;
    bus1.req = 4'hF;
    bus3.req = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_gnt", bus1.gnt, 0);
      check("rst_done", bus1.done, 0);
      check("rst_result", bus1.result, 0);
      check("rst_busy", bus1.busy, 0);
      check("rst_alu", {bus1.alu_s, bus1.alu_a, bus1.alu_b}, 0);
      check("rst_gnt3", bus3.gnt, 0);
    end
    bus1.req = '0;
    bus3.req = '0;
    rst_n    = 1'b1;

    // Simultaneous requests: grant order 0..3, one op every 2 cycles
    for (int k = 0; k < 4; k++) set_op1(k, sim_s[k], sim_a[k], sim_b[k]);
    bus1.req = 4'hF;
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("sim_gnt%0d", j), bus1.gnt, 1 << j);
      check($sformatf("sim_busy%0d", j), bus1.busy, 1);
      bus1.req[j] = 1'b0;
      step();
      check($sformatf("sim_done%0d", j), bus1.done, 1 << j);
      check($sformatf("sim_res%0d", j), bus1.result, sim_r[j]);
      check($sformatf("sim_gnt_off%0d", j), bus1.gnt, 0);
    end

    // Vector table: single ops, one requester at a time
    do_reset();
    for (int v = 0; v < 8; v++) begin
      set_op1(vecs[v].k, vecs[v].s, vecs[v].a, vecs[v].b);
      bus1.req = 4'(1 << vecs[v].k);
      step();
      check($sformatf("vec%0d_gnt", v), bus1.gnt, 1 << vecs[v].k);
      check($sformatf("vec%0d_busy", v), bus1.busy, 1);
      check($sformatf("vec%0d_alu", v), {bus1.alu_s, bus1.alu_a, bus1.alu_b},
            {vecs[v].s, vecs[v].a, vecs[v].b});
      bus1.req = '0;
      set_op1(vecs[v].k, ~vecs[v].s, ~vecs[v].a, ~vecs[v].b);
      step();
      check($sformatf("vec%0d_done", v), bus1.done, 1 << vecs[v].k);
      check($sformatf("vec%0d_res", v), bus1.result, vecs[v].exp);
      check($sformatf("vec%0d_idle", v), bus1.busy, 0);
      step();
      check($sformatf("vec%0d_hold", v), bus1.result, vecs[v].exp);
      check($sformatf("vec%0d_done_off", v), bus1.done, 0);
      check($sformatf("vec%0d_alu_keep", v), {bus1.alu_s, bus1.alu_a, bus1.alu_b},
            {vecs[v].s, vecs[v].a, vecs[v].b});
    end

    // Fairness: req 1 and 3 held on both latencies
    bus1.req = '0;
    do_reset();
    set_op1(1, 2'd0, 3'd1, 3'd2);
    set_op1(3, 2'd3, 3'd5, 3'd2);
    bus3.op_flat = bus1.op_flat;
    bus3.a_flat  = bus1.a_flat;
    bus3.b_flat  = bus1.b_flat;
    bus1.req = 4'b1010;
    bus3.req = 4'b1010;
    for (int s = 1; s <= 24; s++) begin
      step();
      if (s <= 12) begin
        fair_exp(s, 1, g, d, r, b);
        check($sformatf("fair1_gnt_c%0d", s), bus1.gnt, g);
        check($sformatf("fair1_done_c%0d", s), bus1.done, d);
        check($sformatf("fair1_busy_c%0d", s), bus1.busy, b);
        if (d != 0) check($sformatf("fair1_res_c%0d", s), bus1.result, r);
        if (s == 12) bus1.req = '0;
      end
      fair_exp(s, 3, g, d, r, b);
      check($sformatf("fair3_gnt_c%0d", s), bus3.gnt, g);
      check($sformatf("fair3_done_c%0d", s), bus3.done, d);
      check($sformatf("fair3_busy_c%0d", s), bus3.busy, b);
      if (d != 0) check($sformatf("fair3_res_c%0d", s), bus3.result, r);
    end
    bus3.req = '0;

    // Reset during EXEC discards the op; pointer restarts at 0
    do_reset();
    set_op1(2, 2'd0, 3'd1, 3'd1);
    bus1.req = 4'b0100;
    step();
    check("midrst_gnt2", bus1.gnt, 4'b0100);
    rst_n    = 1'b0;
    bus1.req = '0;
    step();
    check("midrst_busy", bus1.busy, 0);
    check("midrst_done", bus1.done, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("midrst_no_done_c%0d", c), bus1.done, 0);
    end
    bus1.req = 4'b1001;
    step();
    check("midrst_first_gnt", bus1.gnt, 4'b0001);
    bus1.req = 4'b0000;
    step();
    check("midrst_first_done", bus1.done, 4'b0001);

    // Randomized run against the model
    do_reset();
    m_busy = 1'b0; m_ptr = 0; m_edge = 0; m_done_at = 0; m_owner = 0;
    m_res  = '0; m_s = '0; m_a = '0; m_b = '0;
    for (int c = 0; c < 300; c++) begin
      model_edge(1);
      step();
      check($sformatf("rnd_gnt_c%0d", c), bus1.gnt, e_gnt);
      check($sformatf("rnd_done_c%0d", c), bus1.done, e_done);
      check($sformatf("rnd_busy_c%0d", c), bus1.busy, m_busy);
      check($sformatf("rnd_res_c%0d", c), bus1.result, m_res);
      check($sformatf("rnd_alu_c%0d", c), {bus1.alu_s, bus1.alu_a, bus1.alu_b}, {m_s, m_a, m_b});
      for (int k = 0; k < 4; k++) begin
        if (bus1.gnt[k]) begin
          set_op1(k, 2'($urandom), 3'($urandom), 3'($urandom));
          if ($urandom_range(3) != 0) bus1.req[k] = 1'b0;
        end else if (!bus1.req[k] && $urandom_range(9) < 3) begin
          set_op1(k, 2'($urandom), 3'($urandom), 3'($urandom));
          bus1.req[k] = 1'b1;
        end
      end
    end
    bus1.req = '0;

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_op1(i % 4, 2'd0, 3'd1, 3'd1);
      bus1.req = 4'(1 << (i % 4));
      step();
      bus1.req = '0;
      step();
    end
    check("stats_count10", op_count1, 10);
    do_reset();
    check("stats_reset", op_count1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
